// File: rtl/openofdm_rx_byte_packer.sv
// Packs the OFDM receiver's header strobe, byte stream and FCS verdict into
// 64-bit stream words (header, data..., status with tlast) behind a FWFT FIFO.
//
// state  | meaning
// IDLE   | waiting for an accepted header strobe
// PACK   | collecting bytes into lanes, watching for FCS or idle timeout
// STATUS | one cycle: push the status word and pulse pkt_done_strobe
module openofdm_rx_byte_packer #(
    parameter int          FIFO_AW = 4,
    parameter logic [15:0] MAX_LEN = 16'd4095
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        soft_rst,
    input  logic        pkt_header_valid_strobe,
    input  logic        pkt_header_valid,
    input  logic [7:0]  pkt_rate,
    input  logic [15:0] pkt_len,
    input  logic        byte_out_strobe,
    input  logic [7:0]  byte_out,
    input  logic        fcs_out_strobe,
    input  logic        fcs_ok,
    input  logic [15:0] timeout_th,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        overflow_sticky,
    output logic        pkt_done_strobe
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {IDLE, PACK, STATUS} state_t;

    state_t      state, state_nxt;
    logic [15:0] len_q, rate_pad, cnt_q, cnt_inc, cnt_nxt, idle_q;
    logic [7:0]  rate_q;
    logic [63:0] buf_q, buf_ins, buf_nxt;
    logic        fcs_q, tout_q, ovf_q;
    logic [2:0]  lane;
    logic [3:0]  fill;
    logic        hdr_ok, byte_acc, byte_push, part_push, tmo_hit, term;

    logic        push, push_last, done;
    logic [63:0] push_data;
    logic [7:0]  push_keep;

    logic [72:0]      mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr;
    logic             empty, full, pop, wr_en, drop;
    logic [72:0]      head;

    assign rate_pad = {8'h00, rate_q};

    always_comb begin
        hdr_ok    = pkt_header_valid_strobe & pkt_header_valid &
                    (pkt_len != 16'd0) & (pkt_len <= MAX_LEN);
        lane      = cnt_q[2:0];
        cnt_inc   = cnt_q + 16'd1;
        byte_acc  = (state == PACK) & byte_out_strobe & (cnt_q < len_q);
        buf_ins   = buf_q;
        buf_ins[{lane, 3'b000} +: 8] = byte_out;
        byte_push = byte_acc & ((lane == 3'd7) | (cnt_inc == len_q));
        tmo_hit   = (state == PACK) & (timeout_th != 16'd0) & (idle_q == timeout_th) &
                    !byte_out_strobe & !fcs_out_strobe;
        term      = (state == PACK) & (fcs_out_strobe | tmo_hit);
        cnt_nxt   = byte_acc ? cnt_inc : cnt_q;
        buf_nxt   = byte_acc ? buf_ins : buf_q;
        // Terminating cycle flushes a partial word unless it already went out with this byte.
        part_push = term & !byte_push & (cnt_nxt[2:0] != 3'd0) & (cnt_nxt != len_q);
        fill      = byte_push ? ({1'b0, lane} + 4'd1) : {1'b0, cnt_nxt[2:0]};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_data = 64'd0;
        push_keep = 8'h00;
        push_last = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (hdr_ok) begin
                    push      = 1'b1;
                    push_data = {16'hA5A5, 24'd0, pkt_rate, pkt_len};
                    push_keep = 8'hFF;
                    state_nxt = PACK;
                end
            end
            PACK: begin
                if (byte_push | part_push) begin
                    push      = 1'b1;
                    push_data = buf_nxt;
                    push_keep = 8'hFF >> (4'd8 - fill);
                end
                if (term) state_nxt = STATUS;
            end
            STATUS: begin
                push      = 1'b1;
                push_data = {16'h5A5A, len_q, rate_pad[7:0], 5'd0, ovf_q, tout_q, fcs_q, cnt_q};
                push_keep = 8'hFF;
                push_last = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (soft_rst) begin
            state_nxt = IDLE;
            push      = 1'b0;
            done      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_q  <= 16'd0;
            rate_q <= 8'd0;
            cnt_q  <= 16'd0;
            idle_q <= 16'd0;
            buf_q  <= 64'd0;
            fcs_q  <= 1'b0;
            tout_q <= 1'b0;
        end else if (soft_rst) begin
            len_q  <= 16'd0;
            rate_q <= 8'd0;
            cnt_q  <= 16'd0;
            idle_q <= 16'd0;
            buf_q  <= 64'd0;
            fcs_q  <= 1'b0;
            tout_q <= 1'b0;
        end else if (state == IDLE) begin
            if (hdr_ok) begin
                len_q  <= pkt_len;
                rate_q <= pkt_rate;
                cnt_q  <= 16'd0;
                idle_q <= 16'd0;
                buf_q  <= 64'd0;
                fcs_q  <= 1'b0;
                tout_q <= 1'b0;
            end
        end else if (state == PACK) begin
            cnt_q  <= cnt_nxt;
            buf_q  <= (byte_push | part_push) ? 64'd0 : buf_nxt;
            idle_q <= byte_out_strobe ? 16'd0 : idle_q + 16'd1;
            if (fcs_out_strobe) fcs_q  <= fcs_ok;
            else if (tmo_hit)   tout_q <= 1'b1;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign pop   = !empty & m_axis_tready;
    assign wr_en = push & (!full | pop);
    assign drop  = push & full & !pop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
        end else if (soft_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            // A drop in the header cycle itself must still be reported.
            if (drop)                              ovf_q <= 1'b1;
            else if ((state == IDLE) && hdr_ok)    ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= {push_last, push_keep, push_data};
    end

    assign head            = mem[rd_ptr[FIFO_AW-1:0]];
    assign m_axis_tvalid   = !empty;
    assign m_axis_tdata    = empty ? 64'd0 : head[63:0];
    assign m_axis_tkeep    = empty ? 8'h00 : head[71:64];
    assign m_axis_tlast    = empty ? 1'b0  : head[72];
    assign overflow_sticky = ovf_q;
    assign pkt_done_strobe = done;

endmodule

// File: tb/tb_openofdm_rx_byte_packer.sv
// Directed plus randomized bench for openofdm_rx_byte_packer with a packet-level
// reference model (expected word list built from byte lists).
module tb_openofdm_rx_byte_packer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        soft_rst;
    logic        pkt_header_valid_strobe, pkt_header_valid;
    logic [7:0]  pkt_rate;
    logic [15:0] pkt_len;
    logic        byte_out_strobe;
    logic [7:0]  byte_out;
    logic        fcs_out_strobe, fcs_ok;
    logic [15:0] timeout_th;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast, m_axis_tvalid, m_axis_tready;
    logic        overflow_sticky, pkt_done_strobe;

    openofdm_rx_byte_packer #(.FIFO_AW(2)) u_dut (
        .clk(clk), .rstn(rstn), .soft_rst(soft_rst),
        .pkt_header_valid_strobe(pkt_header_valid_strobe),
        .pkt_header_valid(pkt_header_valid), .pkt_rate(pkt_rate), .pkt_len(pkt_len),
        .byte_out_strobe(byte_out_strobe), .byte_out(byte_out),
        .fcs_out_strobe(fcs_out_strobe), .fcs_ok(fcs_ok), .timeout_th(timeout_th),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .overflow_sticky(overflow_sticky),
        .pkt_done_strobe(pkt_done_strobe)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } word_t;

    word_t rx_q[$];
    word_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    done_cnt = 0;
    logic  rand_ready = 1'b0;

    always @(negedge clk) begin
        if (rstn && m_axis_tvalid && m_axis_tready)
            rx_q.push_back('{d: m_axis_tdata, k: m_axis_tkeep, l: m_axis_tlast});
        if (rstn && pkt_done_strobe) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_hdr(input logic v, input logic [7:0] r, input logic [15:0] l);
        pkt_header_valid_strobe = 1'b1;
        pkt_header_valid        = v;
        pkt_rate                = r;
        pkt_len                 = l;
        tick();
        pkt_header_valid_strobe = 1'b0;
        pkt_header_valid        = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic with_fcs, input logic ok);
        byte_out_strobe = 1'b1;
        byte_out        = b;
        fcs_out_strobe  = with_fcs;
        fcs_ok          = ok;
        tick();
        byte_out_strobe = 1'b0;
        fcs_out_strobe  = 1'b0;
    endtask

    task automatic send_fcs(input logic ok);
        fcs_out_strobe = 1'b1;
        fcs_ok         = ok;
        tick();
        fcs_out_strobe = 1'b0;
    endtask

    // Expected packet: header, received bytes chunked 8 per word, status word.
    function automatic void model_pkt(input logic [15:0] len, input logic [7:0] rate,
                                      input logic [7:0] b[$], input logic fcs,
                                      input logic tmo, input logic ovf);
        word_t w;
        int    n = b.size();
        exp_q.push_back('{d: {16'hA5A5, 24'd0, rate, len}, k: 8'hFF, l: 1'b0});
        for (int i = 0; i < n; i += 8) begin
            w = '{d: 64'd0, k: 8'h00, l: 1'b0};
            for (int j = 0; j < 8; j++) begin
                if (i + j < n) begin
                    w.d[8*j +: 8] = b[i+j];
                    w.k[j]        = 1'b1;
                end
            end
            exp_q.push_back(w);
        end
        w.d = 64'h5A5A_0000_0000_0000 | (64'(len) << 32) | (64'(rate) << 24) |
              (64'(ovf) << 18) | (64'(tmo) << 17) | (64'(fcs & !tmo) << 16) | 64'(n);
        w.k = 8'hFF;
        w.l = 1'b1;
        exp_q.push_back(w);
    endfunction

    task automatic wait_words(input int n);
        int t = 0;
        while (rx_q.size() < n && t < 400) begin
            tick();
            t++;
        end
        if (rx_q.size() < n) chk("drain_timeout", 64'(rx_q.size()), 64'(n));
    endtask

    task automatic compare_all(input string tag);
        int n;
        chk({tag, "_nwords"}, 64'(rx_q.size()), 64'(exp_q.size()));
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_data"}, rx_q[i].d, exp_q[i].d);
            chk({tag, "_keep_last"}, 64'({rx_q[i].k, rx_q[i].l}), 64'({exp_q[i].k, exp_q[i].l}));
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b[$];
        int d0, len, nb;
        logic ok, same;
        logic [7:0] rate;

        rstn = 1'b0; soft_rst = 1'b0;
        pkt_header_valid_strobe = 1'b0; pkt_header_valid = 1'b0;
        pkt_rate = 8'd0; pkt_len = 16'd0;
        byte_out_strobe = 1'b0; byte_out = 8'd0;
        fcs_out_strobe = 1'b0; fcs_ok = 1'b0;
        timeout_th = 16'd0; m_axis_tready = 1'b1;
        idle(3);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tdata", m_axis_tdata, 64'd0);
        chk("rst_tkeep_tlast", 64'({m_axis_tkeep, m_axis_tlast}), 64'd0);
        chk("rst_ovf_done", 64'({overflow_sticky, pkt_done_strobe}), 64'd0);
        rstn = 1'b1;
        idle(2);

        // Basic 10-byte packet with literal expected words.
        d0 = done_cnt;
        send_hdr(1'b1, 8'h0B, 16'd10);
        for (int i = 1; i <= 10; i++) send_byte(8'(i), 1'b0, 1'b0);
        send_fcs(1'b1);
        wait_words(4);
        chk("t1_nwords", 64'(rx_q.size()), 64'd4);
        if (rx_q.size() >= 4) begin
            chk("t1_hdr", rx_q[0].d, 64'hA5A5_0000_000B_000A);
            chk("t1_d0", rx_q[1].d, 64'h0807060504030201);
            chk("t1_k0", 64'(rx_q[1].k), 64'hFF);
            chk("t1_d1", rx_q[2].d, 64'h0A09);
            chk("t1_k1", 64'(rx_q[2].k), 64'h03);
            chk("t1_status", rx_q[3].d, 64'h5A5A_000A_0B01_000A);
            chk("t1_tlast", 64'({rx_q[0].l, rx_q[1].l, rx_q[2].l, rx_q[3].l}), 64'b0001);
        end
        chk("t1_done", 64'(done_cnt - d0), 64'd1);
        rx_q.delete();

        // 8th byte and FCS in the same cycle: status in the very next cycle.
        b = {};
        for (int i = 0; i < 8; i++) b.push_back(8'(8'h30 + i));
        send_hdr(1'b1, 8'h0D, 16'd8);
        for (int i = 0; i < 7; i++) send_byte(b[i], 1'b0, 1'b0);
        send_byte(b[7], 1'b1, 1'b1);
        chk("t2_done_next", 64'(pkt_done_strobe), 64'd1);
        model_pkt(16'd8, 8'h0D, b, 1'b1, 1'b0, 1'b0);
        wait_words(3);
        compare_all("t2");

        // Rejected headers, then MAX_LEN boundary.
        d0 = done_cnt;
        send_hdr(1'b0, 8'h0B, 16'd10);
        send_hdr(1'b1, 8'h0B, 16'd0);
        send_hdr(1'b1, 8'h0B, 16'd5000);
        send_hdr(1'b1, 8'h0B, 16'd4096);
        send_fcs(1'b1);
        idle(6);
        chk("t3_nowords", 64'(rx_q.size()), 64'd0);
        chk("t3_nodone", 64'(done_cnt - d0), 64'd0);
        b = {};
        send_hdr(1'b1, 8'h0F, 16'd4095);
        send_fcs(1'b1);
        model_pkt(16'd4095, 8'h0F, b, 1'b1, 1'b0, 1'b0);
        wait_words(2);
        compare_all("t3_maxlen");

        // Timeout after 100 idle cycles.
        timeout_th = 16'd100;
        b = {};
        for (int i = 0; i < 5; i++) b.push_back(8'(8'hC0 + i));
        send_hdr(1'b1, 8'h07, 16'd20);
        for (int i = 0; i < 5; i++) send_byte(b[i], 1'b0, 1'b0);
        idle(100);
        @(negedge clk); #1;
        chk("t4_not_early", 64'(rx_q.size()), 64'd1);
        @(negedge clk); #1;
        chk("t4_partial_at_th", 64'(rx_q.size()), 64'd2);
        model_pkt(16'd20, 8'h07, b, 1'b0, 1'b1, 1'b0);
        wait_words(3);
        compare_all("t4");
        timeout_th = 16'd0;

        // Overflow with a 4-deep FIFO and no consumer.
        m_axis_tready = 1'b0;
        b = {};
        for (int i = 0; i < 64; i++) b.push_back(8'($urandom));
        send_hdr(1'b1, 8'h0A, 16'd64);
        for (int i = 0; i < 64; i++) begin
            send_byte(b[i], 1'b0, 1'b0);
            if (i == 30) chk("t5_ovf_before", 64'(overflow_sticky), 64'd0);
            if (i == 31) chk("t5_ovf_5th", 64'(overflow_sticky), 64'd1);
        end
        send_fcs(1'b1);
        idle(3);
        model_pkt(16'd64, 8'h0A, b, 1'b1, 1'b0, 1'b1);
        while (exp_q.size() > 4) void'(exp_q.pop_back());
        m_axis_tready = 1'b1;
        wait_words(4);
        idle(4);
        chk("t5_ovf_hold", 64'(overflow_sticky), 64'd1);
        compare_all("t5");

        // soft_rst mid-packet with the FIFO holding words and overflow flagged.
        m_axis_tready = 1'b0;
        send_hdr(1'b1, 8'h0C, 16'd40);
        for (int i = 0; i < 40; i++) send_byte(8'(i), 1'b0, 1'b0);
        chk("t6_ovf_set", 64'(overflow_sticky), 64'd1);
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        chk("t6_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("t6_ovf_clr", 64'(overflow_sticky), 64'd0);
        m_axis_tready = 1'b1;
        send_byte(8'h55, 1'b0, 1'b0);
        send_fcs(1'b1);
        idle(4);
        chk("t6_idle_after", 64'(rx_q.size()), 64'd0);
        rx_q.delete();

        // Randomized packets; odd iterations get a random consumer on short packets.
        for (int p = 0; p < 30; p++) begin
            rand_ready = p[0];
            len  = rand_ready ? $urandom_range(1, 16) : $urandom_range(1, 48);
            nb   = $urandom_range(0, len + 2);
            rate = 8'($urandom);
            ok   = 1'($urandom_range(0, 1));
            same = 1'($urandom_range(0, 1)) && (nb > 0);
            b = {};
            d0 = done_cnt;
            send_hdr(1'b1, rate, 16'(len));
            for (int i = 0; i < nb; i++) begin
                logic [7:0] v = 8'($urandom);
                if (i < len) b.push_back(v);
                send_byte(v, same && (i == nb - 1), ok);
                idle($urandom_range(0, 2));
            end
            if (!same) send_fcs(ok);
            model_pkt(16'(len), rate, b, ok, 1'b0, 1'b0);
            wait_words(exp_q.size());
            rand_ready = 1'b0;
            m_axis_tready = 1'b1;
            idle(2);
            chk("rnd_done", 64'(done_cnt - d0), 64'd1);
            compare_all("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/openofdm_rx_byte_packer.md
Name: openofdm_rx_byte_packer

Overview:
Sits directly downstream of the OFDM receiver core.
- Consumes its per-packet header strobe, decoded byte stream and FCS verdict.
- Packs bytes into 64-bit stream words framed as: header word, data words, status word (tlast).
- Buffers words in a small FIFO for the DMA/rx interface.
- Reports overflow and timeout so the driver can discard truncated packets.

Parameters:
FIFO_AW, 4, FIFO address width; depth = 2^FIFO_AW words.
MAX_LEN, 16'd4095, largest pkt_len accepted; larger headers are ignored.

Ports:
clk  in  1  receiver clock
rstn  in  1  asynchronous active-low reset
soft_rst  in  1  synchronous clear of FSM, FIFO and flags
pkt_header_valid_strobe  in  1  one-cycle header decode strobe
pkt_header_valid  in  1  header decoded OK (sampled with strobe)
pkt_rate  in  8  rate code, sampled with strobe
pkt_len  in  16  PSDU length in bytes, sampled with strobe
byte_out_strobe  in  1  byte_out valid
byte_out  in  8  decoded byte
fcs_out_strobe  in  1  FCS verdict valid
fcs_ok  in  1  FCS pass
timeout_th  in  16  idle-cycle limit while in a packet; 0 disables
m_axis_tdata  out  64  stream word
m_axis_tkeep  out  8  byte enables, bit i = byte lane [8i+7:8i]
m_axis_tlast  out  1  last word of packet (status word)
m_axis_tvalid  out  1  word available
m_axis_tready  in  1  consumer accepts
overflow_sticky  out  1  a word was dropped in the current or last packet
pkt_done_strobe  out  1  one cycle when the status word is pushed

Behaviour:
Reset (rstn low, or soft_rst high):
- FSM to IDLE; FIFO emptied.
- tvalid, tlast, overflow_sticky and pkt_done_strobe = 0; tdata and tkeep = 0.

FSM states: IDLE, PACK, STATUS.
- IDLE, on strobe & header_valid & 1 <= pkt_len <= MAX_LEN:
  - Push header word: [15:0] pkt_len, [23:16] pkt_rate, [47:24] 0, [63:48] 16'hA5A5, tkeep 8'hFF, tlast 0.
  - Latch len and rate; clear byte counter, lane index, idle counter and overflow_sticky; go to PACK.
  - Any other strobe in IDLE is ignored.
- PACK, on each byte_out_strobe with byte count < len:
  - Byte goes to lane = count[2:0] (little-endian); count increments.
  - When lane 7 is filled, or count reaches len, push a data word. tkeep = ones for filled lanes (e.g. 3 bytes -> 8'h07); unfilled lanes are 0.
  - Bytes arriving after count == len are dropped.
- PACK, on fcs_out_strobe:
  - Latch fcs_ok.
  - Push any partial word not yet pushed. This shares the cycle with the byte push if both occur; at most one push per cycle; a byte on the same cycle is included first.
  - Go to STATUS.
- PACK, idle counter:
  - Counts cycles with no byte_out_strobe; cleared on each byte.
  - When timeout_th != 0 and counter == timeout_th: push the partial word if any, set the timeout flag, go to STATUS.
- STATUS, exactly one cycle later:
  - Push status word: [15:0] bytes received, [16] fcs_ok (0 on timeout), [17] timeout, [18] overflow_sticky, [23:19] 0, [31:24] rate, [47:32] len, [63:48] 16'h5A5A, tkeep 8'hFF, tlast 1.
  - pkt_done_strobe = 1 that cycle; return to IDLE.
- Header strobes in PACK/STATUS are ignored; the timeout terminates stale packets.

FIFO:
- First-word-fall-through; a word pushed in cycle N gives tvalid in N+1.
- Pop when tvalid & tready; simultaneous push and pop is allowed when full.
- Pointers are FIFO_AW+1 bits and wrap naturally.
- Push while full (and no pop that cycle): the word is dropped and overflow_sticky is set. It stays set until the next accepted header or reset.
- The status word on full is also dropped; the consumer detects this by tlast never arriving and a subsequent 16'hA5A5 word.
- tdata/tkeep/tlast are held stable while tvalid & !tready.

Test Plan:
- len 10, rate 8'h0B, bytes 0x01..0x0A, fcs_ok=1, tready=1 -> 4 words:
  - header 64'hA5A5_0000_000B_000A;
  - data 64'h0807060504030201 keep FF;
  - data 64'h0A09 keep 03;
  - status [15:0]=10, bit16=1, tlast=1;
  - pkt_done_strobe one pulse.
- len 8, 8th byte and fcs_out_strobe in the same cycle -> full data word keep FF pushed that cycle, status word the next cycle, tlast only on status.
- Header with pkt_header_valid=0, or pkt_len=0, or pkt_len=5000 -> no words, FSM stays IDLE.
- len 20, only 5 bytes then silence, timeout_th=100 -> after 100 idle cycles: partial word keep 1F, status with count 5, bit17=1, bit16=0.
- FIFO_AW=2, tready=0, len 64 -> overflow_sticky=1 after the 5th push; the first 4 words are preserved intact. Releasing tready yields those 4 words in order, and no tlast.
- soft_rst asserted mid-PACK -> next cycle tvalid=0, FSM IDLE; the next valid header is framed normally with overflow_sticky=0.
